uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between NUM_REQ byte-stream requesters (debug console, status reporter, etc.).
- Round-robin arbitration at packet granularity: a grant is held from the first byte through the byte flagged last.
- Sequences the uart_tx start/busy handshake one byte at a time and flags a uart_tx that never acknowledges.

---
 rtl/uart_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_arb_pkg                                                               |
// | Shared state encoding and width helpers for the UART transmit arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_ACK   = 3'd3,
    S_DONE  = 3'd4
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage : uart_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Combinational round-robin pick: first asserted request at/after ptr.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant_oh,
  output logic [IDW-1:0] grant_idx,
  output logic           any_req
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_pos;

  // Scan offsets high to low so the smallest offset from ptr is written last.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    w_sum     = '0;
    w_pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (IDW + 1)'(k);
      if (w_sum >= (IDW + 1)'(N)) begin
        w_sum = w_sum - (IDW + 1)'(N);
      end
      w_pos = w_sum[IDW-1:0];
      if (req[w_pos]) begin
        grant_oh        = '0;
        grant_oh[w_pos] = 1'b1;
        grant_idx       = w_pos;
      end
    end
  end

  assign any_req = |req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter                                                            |
// | Packet-granular round-robin sharing of one uart_tx between requesters.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_ack_timeout
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = cnt_width(ACK_TIMEOUT);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic               r_grant_valid;
  logic [IDW-1:0]     r_grant_id;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic [IDW-1:0]     r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [7:0]         r_tx_data;
  logic               r_last;
  logic               r_err;

  logic [NUM_REQ-1:0] w_sel_oh;
  logic [IDW-1:0]     w_sel_idx;
  logic               w_any_req;
  logic [CW-1:0]      w_cnt_inc;
  logic               w_grant_en;
  logic               w_load_en;
  logic               w_timeout;
  logic               w_release;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant_oh  (w_sel_oh),
    .grant_idx (w_sel_idx),
    .any_req   (w_any_req)
  );

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_en   = 1'b0;
    w_load_en    = 1'b0;
    w_timeout    = 1'b0;
    w_release    = 1'b0;
    req_ready    = '0;
    tx_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_en   = 1'b1;
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!tx_busy) begin
          req_ready = r_grant_oh;
          if (|(req_valid & r_grant_oh)) begin
            w_load_en    = 1'b1;
            w_next_state = S_START;
          end
        end
      end
      S_START: begin
        tx_start     = 1'b1;
        w_next_state = S_ACK;
      end
      S_ACK: begin
        // Flag fires on the edge where the count steps onto ACK_TIMEOUT-1.
        if (tx_busy) begin
          w_next_state = S_DONE;
        end else if (w_cnt_inc == CW'(ACK_TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          w_release    = r_last;
          w_next_state = r_last ? S_IDLE : S_LOAD;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_grant_oh    <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_tx_data     <= '0;
      r_last        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_grant_en) begin
        r_grant_valid <= 1'b1;
        r_grant_id    <= w_sel_idx;
        r_grant_oh    <= w_sel_oh;
      end
      if (w_load_en) begin
        r_tx_data <= req_data[{r_grant_id, 3'b000} +: 8];
        r_last    <= |(req_last & r_grant_oh);
      end
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_ACK) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_release) begin
        r_grant_valid <= 1'b0;
        r_grant_oh    <= '0;
        r_ptr         <= (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
      end
    end
  end

  assign tx_data         = r_tx_data;
  assign grant_valid     = r_grant_valid;
  assign grant_id        = r_grant_id;
  assign err_ack_timeout = r_err;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                         |
// | Packet-level reference model plus behavioural uart_tx for the arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int IDW         = $clog2(NUM_REQ);
  localparam int DEPTH       = 256;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic                 err_ack_timeout;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id),
    .err_ack_timeout (err_ack_timeout)
  );

  always #5 clk = ~clk;

  // Per-requester byte queues: bit 8 marks the last byte of a packet.
  logic [8:0]         mem [NUM_REQ][DEPTH];
  int                 head [NUM_REQ];
  int                 tail [NUM_REQ];
  int                 mpos [NUM_REQ];
  logic [NUM_REQ-1:0] stall;
  bit                 stuck;

  logic [7:0] rxlog [1024];
  int         rxn;
  int         nstart;
  int         cyc;
  int         last_start_cyc;
  int         err_rise_cyc;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Engine: drives requesters and uart_tx, and checks against the packet model.
  initial begin : engine
    int m_owner, m_ptr, since, ack_wait, frame_left, exp_id;
    bit tracking, m_err, pkt_done, prev_gv, prev_start, prev_err;
    logic [7:0]         last_sent;
    logic [NUM_REQ-1:0] pend, mask, vtmp;
    m_owner = -1; m_ptr = 0; since = 0; ack_wait = 0; frame_left = 0; exp_id = -1;
    tracking = 0; m_err = 0; pkt_done = 0; prev_gv = 0; prev_start = 0; prev_err = 0;
    last_sent = 8'h00; pend = '0; mask = '0; vtmp = '0;
    rxn = 0; nstart = 0; cyc = 0; last_start_cyc = 0; err_rise_cyc = 0;
    for (int r = 0; r < NUM_REQ; r++) begin head[r] = 0; mpos[r] = 0; end
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; tracking = 0; m_err = 0; pkt_done = 0;
        prev_gv = 0; prev_start = 0; prev_err = 0; last_sent = 8'h00;
        for (int r = 0; r < NUM_REQ; r++) mpos[r] = head[r];
      end else begin
        for (int r = 0; r < NUM_REQ; r++) if (pend[r]) head[r]++;
        if (grant_valid && !prev_gv) begin
          check("grant_while_owned", m_owner, -1);
          exp_id = -1;
          for (int k = 0; k < NUM_REQ; k++) begin
            vtmp = req_valid >> ((m_ptr + k) % NUM_REQ);
            if (exp_id < 0 && vtmp[0]) exp_id = (m_ptr + k) % NUM_REQ;
          end
          check("grant_id", grant_id, exp_id);
          m_owner  = (exp_id >= 0) ? exp_id : int'(grant_id);
          pkt_done = 0;
        end else if (!grant_valid && prev_gv) begin
          check("release_after_last", pkt_done, 1);
          if (m_owner >= 0) m_ptr = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end else if (grant_valid) begin
          check("grant_hold", grant_id, m_owner);
        end
        mask = '0;
        if (grant_valid && !tx_busy && m_owner >= 0 && !pkt_done) mask = NUM_REQ'(1) << m_owner;
        check("ready_mask", req_ready & ~mask, 0);
        if (tx_start) begin
          check("start_single", prev_start, 0);
          check("start_granted", grant_valid, 1);
          if (m_owner >= 0) begin
            check("start_in_packet", pkt_done, 0);
            check("tx_data", tx_data, mem[m_owner][mpos[m_owner]][7:0]);
            pkt_done = mem[m_owner][mpos[m_owner]][8];
            mpos[m_owner]++;
          end
          rxlog[rxn] = tx_data; rxn++;
          last_sent = tx_data; nstart++; last_start_cyc = cyc;
          tracking = 1; since = 0;
          if (!stuck) ack_wait = int'($urandom_range(1, 4));
        end else begin
          check("tx_data_hold", tx_data, last_sent);
          if (tracking) begin
            since++;
            if (since == ACK_TIMEOUT) begin m_err = 1; tracking = 0; end
            else if (tx_busy) tracking = 0;
          end
        end
        check("err_flag", err_ack_timeout, m_err);
        if (err_ack_timeout && !prev_err) err_rise_cyc = cyc;
        prev_gv = grant_valid; prev_start = tx_start; prev_err = err_ack_timeout;
      end
      // Behavioural uart_tx: busy rises 1..4 cycles after start, frame of 2..12 cycles.
      if (ack_wait > 0) begin
        ack_wait--;
        if (ack_wait == 0) begin tx_busy = 1'b1; frame_left = int'($urandom_range(2, 12)); end
      end else if (tx_busy) begin
        frame_left--;
        if (frame_left == 0) tx_busy = 1'b0;
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        if (head[r] < tail[r]) begin
          req_valid[r]       = ~stall[r];
          req_data[r*8 +: 8] = mem[r][head[r]][7:0];
          req_last[r]        = mem[r][head[r]][8];
        end else begin
          req_valid[r]       = 1'b0;
          req_data[r*8 +: 8] = 8'h00;
          req_last[r]        = 1'b0;
        end
      end
      #1;
      pend = req_valid & req_ready;
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic push(input int r, input logic [7:0] b, input bit last);
    mem[r][tail[r]] = {last, b};
    tail[r]++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int  n;
    bit  done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      tick(); n++;
      done = !grant_valid;
      for (int r = 0; r < NUM_REQ; r++) if (head[r] != tail[r] || mpos[r] != tail[r]) done = 0;
    end
    check(name, done, 1);
  endtask

  task automatic check_log(input string name, input int base, input logic [63:0] exp, input int n);
    check({name, "_count"}, rxn - base, n);
    for (int i = 0; i < n; i++) check(name, rxlog[base + i], exp[8*(n-1-i) +: 8]);
  endtask

  initial begin : main
    int base, s0, h0, r, len, w, sr;
    rst_n = 1'b0; stuck = 1'b0; stall = '0;
    for (int i = 0; i < NUM_REQ; i++) tail[i] = 0;
    tick();
    for (int i = 0; i < NUM_REQ; i++) push(i, 8'hC0 + 8'(i), 1'b1);
    repeat (5) begin
      tick();
      check("reset_outputs", {grant_valid, tx_start, err_ack_timeout, req_ready, grant_id, tx_data}, 0);
    end
    check("reset_all_valid", req_valid, 4'hF);
    base = rxn;
    rst_n = 1'b1;
    tick();
    check("first_grant", {grant_valid, grant_id}, 3'b100);
    check("first_ready", req_ready, 4'b0001);
    tick();
    check("first_start", tx_start, 1);
    check("first_byte", tx_data, 8'hC0);
    wait_idle("drain_reset", 2000);
    check_log("log_reset", base, 64'hC0C1C2C3, 4);

    base = rxn; s0 = nstart;
    push(2, 8'h55, 1'b0); push(2, 8'hA5, 1'b0); push(2, 8'h0F, 1'b1);
    wait_idle("drain_single", 2000);
    check("single_starts", nstart - s0, 3);
    check_log("log_single", base, 64'h55A50F, 3);

    base = rxn;
    push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b1);
    push(0, 8'h13, 1'b1);
    wait_idle("drain_contend", 3000);
    check_log("log_contend", base, 64'h1112212213, 5);

    push(2, 8'h2A, 1'b1);
    wait_idle("drain_pre_wrap", 1000);
    base = rxn;
    push(0, 8'h0A, 1'b1); push(3, 8'h3A, 1'b1);
    wait_idle("drain_wrap", 2000);
    check_log("log_wrap", base, 64'h3A0A, 2);

    base = rxn; h0 = head[0];
    for (int i = 0; i < 5; i++) push(0, 8'h50 + 8'(i), i == 4);
    w = 0;
    while (head[0] < h0 + 2 && w < 500) begin tick(); w++; end
    check("stall_reach", head[0] >= h0 + 2, 1);
    stall[0] = 1'b1;
    push(1, 8'h61, 1'b1);
    repeat (50) begin
      tick();
      check("stall_hold", {grant_valid, grant_id}, 3'b100);
      check("stall_no_ready1", req_ready[1], 0);
    end
    stall[0] = 1'b0;
    wait_idle("drain_stall", 2000);
    check_log("log_stall", base, 64'h50515253_5461, 6);

    for (int p = 0; p < 40; p++) begin
      r   = int'($urandom_range(0, NUM_REQ - 1));
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) push(r, 8'($urandom), i == len - 1);
      w = int'($urandom_range(0, 25));
      repeat (w) begin
        tick();
        if ($urandom_range(0, 9) == 0) begin
          sr = int'($urandom_range(0, NUM_REQ - 1));
          stall[sr] = ~stall[sr];
        end
      end
    end
    stall = '0;
    wait_idle("drain_random", 20000);

    stuck = 1'b1;
    push(1, 8'h77, 1'b1);
    wait_idle("drain_timeout", 500);
    check("timeout_flag", err_ack_timeout, 1);
    check("timeout_latency", err_rise_cyc - last_start_cyc, ACK_TIMEOUT);
    repeat (20) tick();
    check("timeout_sticky", err_ack_timeout, 1);
    check("timeout_idle", grant_valid, 0);
    rst_n = 1'b0;
    tick(); tick();
    check("timeout_cleared", err_ack_timeout, 0);
    rst_n = 1'b1; stuck = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
